// File: rtl/sst_pkg.sv
// Shared types and constants for the mapper save-state bus sequencer.
package sst_pkg;

    localparam int             SST_IDX_W      = 8;
    localparam logic [7:0]     SST_IDX_MAPIDX = 8'd127;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_PUSH,
        ST_WR_FETCH,
        ST_WR_HOLD,
        ST_WR_REL,
        ST_FIN
    } sst_seq_state_t;

    // An inverted index window means the session carries no transfers.
    function automatic logic sst_range_empty(input logic [SST_IDX_W-1:0] first,
                                             input logic [SST_IDX_W-1:0] last);
        return first > last;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus a registered falling-edge pulse.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic fall_o
);

    logic q1_q, q2_q, fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_q   <= 1'b0;
            q2_q   <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            q1_q   <= d_i;
            q2_q   <= q1_q;
            fall_q <= q2_q & ~q1_q;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/sst_reg_sequencer.sv
// Save-state bus initiator: SAVE streams mapper registers out, RESTORE writes a byte
// stream back, holding each write until the mapper's m2 falling edge has captured it.
module sst_reg_sequencer
    import sst_pkg::*;
#(
    parameter int RD_SETTLE = 2,
    parameter int M2_TO     = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_start,
    input  logic                 cmd_dir,
    input  logic [SST_IDX_W-1:0] cmd_first,
    input  logic [SST_IDX_W-1:0] cmd_last,
    input  logic                 cmd_abort,
    output logic                 busy,
    output logic                 done,
    output logic                 err_to,
    input  logic                 m2,
    output logic                 sst_act,
    output logic                 sst_we_reg,
    output logic [SST_IDX_W-1:0] sst_addr,
    output logic [7:0]           sst_dato,
    input  logic [7:0]           sst_di,
    output logic [7:0]           sv_data,
    output logic                 sv_valid,
    input  logic                 sv_ready,
    input  logic [7:0]           rs_data,
    input  logic                 rs_valid,
    output logic                 rs_ready
);

    localparam int SET_W = (RD_SETTLE > 1) ? $clog2(RD_SETTLE) : 1;
    localparam int TO_W  = (M2_TO > 1) ? $clog2(M2_TO) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(RD_SETTLE - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(M2_TO - 1);
    // Edges seen in the first SYNC_LAG hold cycles fell before the strobe was raised.
    localparam logic [TO_W-1:0]  SYNC_LAG = TO_W'(2);

    sst_seq_state_t       state_q, state_d;
    logic [SST_IDX_W-1:0] idx_q, idx_d, last_q, last_d, addr_q, addr_d;
    logic [SET_W-1:0]     set_q, set_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic                 act_q, act_d, busy_q, busy_d, err_q, err_d, we_q, we_d;
    logic                 svv_q, svv_d;
    logic [7:0]           dato_q, dato_d, svd_q, svd_d;
    logic                 m2_fall;

    sync_edge u_m2_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (m2),
        .fall_o (m2_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            addr_q  <= '0;
            set_q   <= '0;
            to_q    <= '0;
            act_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            svv_q   <= 1'b0;
            dato_q  <= '0;
            svd_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            set_q   <= set_d;
            to_q    <= to_d;
            act_q   <= act_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            we_q    <= we_d;
            svv_q   <= svv_d;
            dato_q  <= dato_d;
            svd_q   <= svd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        addr_d   = addr_q;
        set_d    = set_q;
        to_d     = to_q;
        act_d    = act_q;
        busy_d   = busy_q;
        err_d    = err_q;
        we_d     = we_q;
        svv_d    = svv_q;
        dato_d   = dato_q;
        svd_d    = svd_q;
        rs_ready = 1'b0;
        done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    idx_d  = cmd_first;
                    last_d = cmd_last;
                    addr_d = cmd_first;
                    set_d  = '0;
                    act_d  = 1'b1;
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    if (sst_range_empty(cmd_first, cmd_last)) state_d = ST_FIN;
                    else if (cmd_dir)                         state_d = ST_WR_FETCH;
                    else                                      state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (cmd_abort) begin
                    state_d = ST_FIN;
                end else if (set_q == SET_LAST) begin
                    svd_d   = sst_di;
                    svv_d   = 1'b1;
                    state_d = ST_RD_PUSH;
                end else begin
                    set_d = set_q + 1'b1;
                end
            end
            ST_RD_PUSH: begin
                if (sv_ready) begin
                    svv_d = 1'b0;
                    if (idx_q == last_q) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        addr_d  = idx_q + 1'b1;
                        set_d   = '0;
                        state_d = ST_RD_WAIT;
                    end
                end else if (cmd_abort) begin
                    svv_d   = 1'b0;
                    state_d = ST_FIN;
                end
            end
            ST_WR_FETCH: begin
                rs_ready = ~cmd_abort;
                if (cmd_abort) begin
                    state_d = ST_FIN;
                end else if (rs_valid) begin
                    dato_d  = rs_data;
                    addr_d  = idx_q;
                    we_d    = 1'b1;
                    to_d    = '0;
                    state_d = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD: begin
                // Abort is deliberately ignored: an issued write must complete or time out.
                if (m2_fall && (to_q >= SYNC_LAG)) begin
                    we_d    = 1'b0;
                    state_d = ST_WR_REL;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    we_d    = 1'b0;
                    state_d = ST_FIN;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            ST_WR_REL: begin
                if (idx_q == last_q) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_WR_FETCH;
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                act_d   = 1'b0;
                busy_d  = 1'b0;
                svv_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy       = busy_q;
    assign err_to     = err_q;
    assign sst_act    = act_q;
    assign sst_we_reg = we_q;
    assign sst_addr   = addr_q;
    assign sst_dato   = dato_q;
    assign sv_data    = svd_q;
    assign sv_valid   = svv_q;

endmodule
